ehl_or: RTL and testbench

EHL_OR -- requirements
Module: ehl_or

---
 rtl/ehl_or.sv | 87 ++++++++
 tb/tb_ehl_or.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ehl_or.sv
// ehl_or -- bitwise two-input OR with a registered copy and a toggle counter.
//
// Parameters
//   TECHNOLOGY : 0 = generic behavioural OR; 1/2 = per-bit OR cell instances;
//                any other value falls back to generic.
//   WIDTH      : data width (1..64).
//   CNT_W      : toggle counter width (4..32).
// Ports
//   clk        : rising-edge clock for data_q / toggle_cnt.
//   rst        : synchronous active-high reset.
//   data_a/b   : OR operands; may carry clocks or asynchronous signals.
//   data_o     : combinational data_a | data_b (no clock/reset dependence).
//   data_q     : data_o registered once.
//   toggle_cnt : saturating count of cycles in which data_q changed.

// Cell flavour A: plain gate primitive, a single OR stage.
module ehl_or_cell_a (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  or u_or (o_y, i_a, i_b);
endmodule

// Cell flavour B: single-stage OR modelled as an operator.
module ehl_or_cell_b (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_a | i_b;
endmodule

module ehl_or #(
  parameter int TECHNOLOGY = 0,
  parameter int WIDTH      = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] data_q,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;

  // One OR cell per bit, nothing else in the path: a clock-OR built from
  // these has no reconvergence and therefore no extra glitch source.
  generate
    if (TECHNOLOGY == 1) begin : g_cell_a
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ehl_or_cell_a u_cell (.i_a(data_a[i]), .i_b(data_b[i]), .o_y(w_or[i]));
      end
    end else if (TECHNOLOGY == 2) begin : g_cell_b
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ehl_or_cell_b u_cell (.i_a(data_a[i]), .i_b(data_b[i]), .o_y(w_or[i]));
      end
    end else begin : g_generic
      assign w_or = data_a | data_b;
    end
  endgenerate

  assign data_o = w_or;

  // No initial values: state is unknown until the first reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else begin
      r_q <= w_or;
      // Count a cycle when the value about to load differs from data_q;
      // stop at all-ones and hold there until reset.
      if ((w_or != r_q) && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign data_q     = r_q;
  assign toggle_cnt = r_cnt;

endmodule

// File: tb/tb_ehl_or.sv
module tb_ehl_or;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Equivalence pair: generic vs cell implementation, WIDTH=1.
  logic ea = 1'b0, eb = 1'b0, erst = 1'b1;
  logic        g_o, g_q, t_o, t_q;
  logic [15:0] g_cnt, t_cnt;

  // Registered path / saturation / mid-run reset, CNT_W=4.
  logic sa = 1'b0, sb = 1'b0, srst = 1'b1;
  logic       s_o, s_q;
  logic [3:0] s_cnt;

  // Width test, WIDTH=8, second cell flavour.
  logic [7:0]  wa = '0, wb = '0;
  logic        wrst = 1'b1;
  logic [7:0]  w_o, w_q;
  logic [15:0] w_cnt;

  ehl_or #(.TECHNOLOGY(0), .WIDTH(1), .CNT_W(16)) u_gen (
    .clk(clk), .rst(erst), .data_a(ea), .data_b(eb),
    .data_o(g_o), .data_q(g_q), .toggle_cnt(g_cnt));

  ehl_or #(.TECHNOLOGY(1), .WIDTH(1), .CNT_W(16)) u_tech (
    .clk(clk), .rst(erst), .data_a(ea), .data_b(eb),
    .data_o(t_o), .data_q(t_q), .toggle_cnt(t_cnt));

  ehl_or #(.TECHNOLOGY(0), .WIDTH(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(srst), .data_a(sa), .data_b(sb),
    .data_o(s_o), .data_q(s_q), .toggle_cnt(s_cnt));

  ehl_or #(.TECHNOLOGY(2), .WIDTH(8), .CNT_W(16)) u_wide (
    .clk(clk), .rst(wrst), .data_a(wa), .data_b(wb),
    .data_o(w_o), .data_q(w_q), .toggle_cnt(w_cnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- truth table on both implementations ----------------
    ea = 0; eb = 0; #1; chk("tt00_gen", 64'(g_o), 64'd0); chk("tt00_tech", 64'(t_o), 64'd0);
    ea = 0; eb = 1; #1; chk("tt01_gen", 64'(g_o), 64'd1); chk("tt01_tech", 64'(t_o), 64'd1);
    ea = 1; eb = 0; #1; chk("tt10_gen", 64'(g_o), 64'd1); chk("tt10_tech", 64'(t_o), 64'd1);
    ea = 1; eb = 1; #1; chk("tt11_gen", 64'(g_o), 64'd1); chk("tt11_tech", 64'(t_o), 64'd1);
    ea = 1; eb = 1'bx; #1; chk("tt1x_tech", 64'(t_o), 64'd1); chk("tt1x_gen", 64'(g_o), 64'd1);
    // 0|x: both implementations must resolve identically.
    ea = 0; eb = 1'bx; #1; chk("tt0x_equiv", 64'(t_o), 64'(g_o));
    ea = 0; eb = 1'bz; #1; chk("tt0z_equiv", 64'(t_o), 64'(g_o));

    // ---------------- clock-OR equivalence: periods 20 and 30 ----------------
    // Steps of 5 cover every edge of both clocks; 120 steps = 20 slow periods.
    for (int k = 0; k < 120; k++) begin
      ea = ((k / 2) % 2) != 0;
      eb = ((k / 3) % 2) != 0;
      #1;
      chk("eq_tech_vs_gen", 64'(t_o), 64'(g_o));
      chk("eq_tech_vs_or", 64'(t_o), 64'(ea | eb));
      #4;
    end

    // ---------------- registered path ----------------
    srst = 1; sa = 0; sb = 0;
    tick(); tick();
    chk("rst_q", 64'(s_q), 64'd0);
    chk("rst_cnt", 64'(s_cnt), 64'd0);
    srst = 0; sa = 1; sb = 0;
    #1;
    chk("reg_o_now", 64'(s_o), 64'd1);
    chk("reg_q_before_edge", 64'(s_q), 64'd0);
    tick();
    chk("reg_q_after_edge", 64'(s_q), 64'd1);
    chk("reg_cnt_1", 64'(s_cnt), 64'd1);
    // unchanged input: no increment
    tick();
    chk("reg_cnt_hold", 64'(s_cnt), 64'd1);

    // ---------------- mid-run reset at toggle_cnt=5 ----------------
    for (int k = 0; k < 4; k++) begin
      sa = ~sa;
      tick();
    end
    chk("mid_cnt_5", 64'(s_cnt), 64'd5);
    chk("mid_q_pre", 64'(s_q), 64'd1);
    srst = 1; sa = 0;
    #1; chk("mid_o_in_rst0", 64'(s_o), 64'd0);
    sa = 1;
    #1; chk("mid_o_in_rst1", 64'(s_o), 64'd1);
    tick();
    // load of 1 would not change q, but reset forces 0 anyway
    chk("mid_q_rst", 64'(s_q), 64'd0);
    chk("mid_cnt_rst", 64'(s_cnt), 64'd0);
    chk("mid_o_after", 64'(s_o), 64'd1);
    srst = 0;
    tick();
    chk("post_rst_q", 64'(s_q), 64'd1);
    chk("post_rst_cnt", 64'(s_cnt), 64'd1);

    // ---------------- saturation at 15 ----------------
    for (int k = 1; k <= 20; k++) begin
      sa = ~sa;
      tick();
      chk("sat_q", 64'(s_q), 64'(sa));
      if (k == 13) chk("sat_cnt_14", 64'(s_cnt), 64'd14);
      if (k == 14) chk("sat_cnt_15", 64'(s_cnt), 64'd15);
      if (k == 20) chk("sat_cnt_hold", 64'(s_cnt), 64'd15);
    end

    // ---------------- width 8 ----------------
    wrst = 1; tick();
    chk("w_rst_q", 64'(w_q), 64'd0);
    chk("w_rst_cnt", 64'(w_cnt), 64'd0);
    wrst = 0; wa = 8'hA5; wb = 8'h0F;
    #1;
    chk("w_o_now", 64'(w_o), 64'hAF);
    chk("w_q_before", 64'(w_q), 64'd0);
    tick();
    chk("w_q_after", 64'(w_q), 64'hAF);
    chk("w_cnt_1", 64'(w_cnt), 64'd1);
    wa = 8'h50; wb = 8'h00;
    #1; chk("w_o_50", 64'(w_o), 64'h50);
    tick();
    chk("w_q_50", 64'(w_q), 64'h50);
    chk("w_cnt_2", 64'(w_cnt), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
